// File: rtl/uart_tx_scheduler_if.sv
// Purpose: bundle of request, transmitter and status signals for uart_tx_scheduler.
// Latency: none; this is wiring only.
// Backpressure: tx_ready/tx_done from the transmitter gate the scheduler; requesters are never stalled.
// Ports: master = request/transmitter side (drives requests, tx_ready, tx_done, ovr_clr);
//        slave  = scheduler (drives tx_start, tx_data, grant, pending, overrun, timeout).
interface uart_tx_scheduler_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [N-1:0]    req_pulse;
    logic [N*DW-1:0] req_data;
    logic            tx_ready;
    logic            tx_done;
    logic            ovr_clr;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    pending;
    logic [N-1:0]    overrun;
    logic            timeout;

    modport master (
        output req_pulse, req_data, tx_ready, tx_done, ovr_clr,
        input  tx_start, tx_data, grant, pending, overrun, timeout
    );

    modport slave (
        input  req_pulse, req_data, tx_ready, tx_done, ovr_clr,
        output tx_start, tx_data, grant, pending, overrun, timeout
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Purpose: round-robin arbiter sharing one UART transmitter among N pulse requesters.
// Latency: req_pulse in cycle 0 -> tx_start/grant in cycle 2; tx_done in k -> next tx_start earliest k+2.
// Backpressure: waits for tx_ready in IDLE and tx_done in BUSY (watchdog abort); extra requests set overrun.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries req_pulse/req_data/tx_ready/
//        tx_done/ovr_clr in and tx_start/tx_data/grant/pending/overrun/timeout out, all registered.
module uart_tx_scheduler #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 0) ? CW_RAW : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  overrun_q, overrun_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [DW-1:0] slot_q [N];
    logic [DW-1:0] slot_d [N];
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          timeout_q, timeout_d;

    logic [IW-1:0] win, win_hi, win_lo;
    logic          found_hi;
    logic [N-1:0]  clr_vec;

    // Rotating priority: lowest pending index at or above ptr, else lowest pending index overall
    // (that is the wrap-around part of the scan). Works for any N, power of two or not.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win_lo = IW'(i);
                if (i >= int'(ptr_q)) begin
                    win_hi   = IW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    // Slot being handed to the transmitter this cycle; its pending bit drops at the end of START.
    always_comb begin
        clr_vec = '0;
        if (state_q == S_START) clr_vec[sel_q] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        pending_d = pending_q;
        slot_d    = slot_q;
        // A fresh overrun below overrides the clear in the same cycle.
        overrun_d = bus.ovr_clr ? '0 : overrun_q;

        case (state_q)
            S_IDLE: begin
                if ((|pending_q) && bus.tx_ready) begin
                    state_d   = S_START;
                    sel_d     = win;
                    tx_data_d = slot_q[win];
                end
            end
            S_START: begin
                state_d = S_BUSY;
                cnt_d   = '0;
            end
            S_BUSY: begin
                if (bus.tx_done || ((TIMEOUT != 0) && (cnt_q == CNT_LAST))) begin
                    state_d = S_IDLE;
                    ptr_d   = (sel_q == IDX_LAST) ? '0 : sel_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < N; i++) begin
            if (clr_vec[i]) pending_d[i] = 1'b0;
            if (bus.req_pulse[i]) begin
                // A slot being started this cycle is free to accept a refill.
                if (!pending_q[i] || clr_vec[i]) begin
                    pending_d[i] = 1'b1;
                    slot_d[i]    = bus.req_data[i*DW +: DW];
                end else begin
                    overrun_d[i] = 1'b1;
                end
            end
        end

        // Outputs are computed for the next state so they can be registered.
        tx_start_d = (state_q == S_IDLE) && (state_d == S_START);
        grant_d    = '0;
        if (state_d != S_IDLE) grant_d[sel_d] = 1'b1;
        // Counter value cnt_d lands in the next cycle; timeout is high in the last BUSY cycle.
        timeout_d  = (TIMEOUT != 0) && (state_d == S_BUSY) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            for (int i = 0; i < N; i++) slot_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
            slot_q     <= slot_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant    = grant_q;
    assign bus.pending  = pending_q;
    assign bus.overrun  = overrun_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: self-checking bench for uart_tx_scheduler (N=4, DW=8, TIMEOUT=16).
// Latency: a cycle-stamped reference model predicts every output in every cycle.
// Backpressure: bench drives tx_ready/tx_done as the transmitter, both directed and random.
module tb_uart_tx_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N(N), .DW(DW)) bus ();

    uart_tx_scheduler #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: slot contents plus time stamps of the current transfer.
    logic [N-1:0]  m_pend;
    logic [DW-1:0] m_dat [N];
    logic [N-1:0]  m_ovr;
    logic [DW-1:0] m_byte;
    int            m_ptr, m_owner, m_start, m_free;

    logic [N-1:0]  log_g [$];
    logic [DW-1:0] log_d [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Advance the model over the current cycle using the inputs driven for it.
    task automatic model_step();
        int clr;
        int w;
        if (rst) begin
            m_pend = '0; m_ovr = '0; m_byte = '0;
            m_ptr = 0; m_owner = -1; m_start = -1; m_free = 0;
            for (int i = 0; i < N; i++) m_dat[i] = '0;
            return;
        end
        clr = (m_owner >= 0 && cyc == m_start) ? m_owner : -1;
        w = -1;
        if (m_owner < 0 && cyc >= m_free && bus.tx_ready) w = pick();
        if (w >= 0) begin
            m_owner = w;
            m_start = cyc + 1;
            m_byte  = m_dat[w];
        end else if (m_owner >= 0 && cyc > m_start && (bus.tx_done || cyc - m_start == TO)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_free  = cyc + 1;
        end
        if (bus.ovr_clr) m_ovr = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req_pulse[i]) begin
                if (!m_pend[i] || clr == i) begin
                    m_pend[i] = 1'b1;
                    m_dat[i]  = bus.req_data[i*DW +: DW];
                end else begin
                    m_ovr[i] = 1'b1;
                end
            end else if (clr == i) begin
                m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("tx_start", 32'(bus.tx_start), 32'(m_owner >= 0 && cyc == m_start));
        chk("grant",    32'(bus.grant),    (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("tx_data",  32'(bus.tx_data),  32'(m_byte));
        chk("pending",  32'(bus.pending),  32'(m_pend));
        chk("overrun",  32'(bus.overrun),  32'(m_ovr));
        chk("timeout",  32'(bus.timeout),  32'(m_owner >= 0 && cyc == m_start + TO));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (bus.tx_start) begin
            log_g.push_back(bus.grant);
            log_d.push_back(bus.tx_data);
        end
        bus.req_pulse = '0;
        bus.tx_done   = 1'b0;
        bus.ovr_clr   = 1'b0;
    endtask

    task automatic req(input int i, input logic [DW-1:0] d);
        bus.req_pulse[i]          = 1'b1;
        bus.req_data[i*DW +: DW]  = d;
    endtask

    task automatic wait_start();
        int k = 0;
        while (!bus.tx_start && k < 40) begin
            tick();
            k++;
        end
        chk("start_seen", 32'(bus.tx_start), 32'd1);
    endtask

    // From the START cycle: answer tx_done in BUSY cycle bc.
    task automatic finish_busy(input int bc);
        repeat (bc) tick();
        bus.tx_done = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int n0;
        rst           = 1'b1;
        bus.req_pulse = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b1;
        bus.tx_done   = 1'b0;
        bus.ovr_clr   = 1'b0;

        // Reset state
        do_reset();
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_grant",    32'(bus.grant),    32'd0);
        chk("rst_pending",  32'(bus.pending),  32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),  32'd0);

        // Single request: pending in cycle 1, start in cycle 2, pending clear in cycle 3
        req(2, 8'hA5);
        tick();
        chk("single_pend_c1",  32'(bus.pending),  32'h4);
        chk("single_start_c1", 32'(bus.tx_start), 32'd0);
        tick();
        chk("single_start_c2", 32'(bus.tx_start), 32'd1);
        chk("single_data",     32'(bus.tx_data),  32'hA5);
        chk("single_grant",    32'(bus.grant),    32'h4);
        tick();
        chk("single_pend_c3",  32'(bus.pending),  32'd0);
        repeat (9) tick();
        bus.tx_done = 1'b1;
        tick();
        chk("single_grant_off", 32'(bus.grant), 32'd0);

        // Round robin from ptr=0
        do_reset();
        log_g.delete();
        log_d.delete();
        for (int i = 0; i < N; i++) req(i, 8'h10 + 8'(i));
        for (int i = 0; i < N; i++) begin
            wait_start();
            finish_busy(5);
        end
        req(0, 8'h20);
        req(3, 8'h23);
        for (int i = 0; i < 2; i++) begin
            wait_start();
            finish_busy(5);
        end
        chk("rr_count", 32'(log_g.size()), 32'd6);
        for (int i = 0; i < N; i++) begin
            chk("rr_grant", 32'(log_g[i]), 32'd1 << i);
            chk("rr_data",  32'(log_d[i]), 32'h10 + 32'(i));
        end
        chk("rr2_grant0", 32'(log_g[4]), 32'h1);
        chk("rr2_data0",  32'(log_d[4]), 32'h20);
        chk("rr2_grant3", 32'(log_g[5]), 32'h8);
        chk("rr2_data3",  32'(log_d[5]), 32'h23);

        // Overrun while pending and not yet started
        bus.tx_ready = 1'b0;
        req(1, 8'h55);
        tick();
        req(1, 8'hAA);
        tick();
        chk("ovr_flag",    32'(bus.overrun), 32'h2);
        chk("ovr_pending", 32'(bus.pending), 32'h2);
        bus.tx_ready = 1'b1;
        wait_start();
        chk("ovr_data",  32'(bus.tx_data), 32'h55);
        chk("ovr_grant", 32'(bus.grant),   32'h2);
        finish_busy(2);
        bus.ovr_clr = 1'b1;
        tick();
        chk("ovr_cleared", 32'(bus.overrun), 32'd0);

        // Refill in the START cycle
        req(2, 8'h11);
        wait_start();
        chk("refill_grant", 32'(bus.grant), 32'h4);
        req(2, 8'h3C);
        tick();
        chk("refill_pending", 32'(bus.pending), 32'h4);
        chk("refill_no_ovr",  32'(bus.overrun), 32'd0);
        bus.tx_done = 1'b1;
        tick();
        wait_start();
        chk("refill_data",   32'(bus.tx_data), 32'h3C);
        chk("refill_grant2", 32'(bus.grant),   32'h4);
        finish_busy(1);

        // Watchdog: no tx_done, abort in BUSY cycle TO
        req(0, 8'h77);
        wait_start();
        k = 0;
        while (!bus.timeout && k < 40) begin
            tick();
            k++;
        end
        chk("wd_busy_cycles", 32'(k), 32'(TO));
        tick();
        chk("wd_idle_grant",   32'(bus.grant),   32'd0);
        chk("wd_pulse_single", 32'(bus.timeout), 32'd0);

        // Reset during BUSY with another request pending
        req(1, 8'h41);
        wait_start();
        req(2, 8'h42);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstbusy_pending", 32'(bus.pending), 32'd0);
        chk("rstbusy_grant",   32'(bus.grant),   32'd0);
        n0 = log_g.size();
        repeat (10) tick();
        chk("rstbusy_no_start", 32'(log_g.size() - n0), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) bus.req_pulse[i] = ($urandom_range(0, 7) == 0);
            bus.req_data = 32'($urandom);
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            bus.tx_done  = (c < 600 || c > 900) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (m_owner >= 0 && cyc == m_start + TO) bus.tx_done = 1'b0;
            bus.ovr_clr  = ($urandom_range(0, 31) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter among N requesters. Each requester presents a single-cycle request pulse, typically produced by a positive-edge detector on a button or status line, plus a data byte. The block latches each request and grants the transmitter to one requester at a time. It issues a single-cycle start strobe with the granted byte and waits for the transmitter's done pulse before it schedules the next request. It sits between the edge-detect/front-panel logic and the UART TX datapath.

## Interface
- N, 4: number of requesters (2..8)
- DW, 8: data width per request
- TIMEOUT, 20000: cycles to wait in BUSY for tx_done before aborting; 0 disables the watchdog
- clk  input  1  system clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high; clears all state
- req_pulse  input  N  one-cycle request strobes, bit i = requester i
- req_data  input  N*DW  request payloads, requester i at bits [i*DW +: DW]
- tx_ready  input  1  transmitter idle, sampled only in IDLE
- tx_done  input  1  one-cycle pulse from transmitter at end of frame
- ovr_clr  input  1  one-cycle pulse; clears all overrun flags
- tx_start  output  1  one-cycle start strobe to transmitter
- tx_data  output  DW  byte for the transmitter, valid from tx_start until the next grant
- grant  output  N  one-hot owner of the transmitter, high in START and BUSY
- pending  output  N  latched, not-yet-started requests
- overrun  output  N  sticky; a request arrived while that requester was already pending
- timeout  output  1  one-cycle pulse when the watchdog aborts BUSY

## Operation
- Per-requester slot: pending bit plus a DW data register.
  - req_pulse[i] with pending[i]=0: capture the requester's payload, set pending[i].
  - req_pulse[i] with pending[i]=1, and not being cleared this cycle: drop the payload, keep the old data, set overrun[i].
  - req_pulse[i] in the same cycle that slot i is cleared by START: capture the new data, pending[i] stays 1, no overrun.
- ovr_clr clears all overrun bits. If ovr_clr and a new overrun occur in the same cycle, the new overrun wins (bit ends at 1).
- FSM states are IDLE, START and BUSY. Reset state is IDLE.
  - IDLE: if pending!=0 and tx_ready=1, select the winner `sel` (rules below), load tx_data from slot sel, and go to START. Otherwise stay in IDLE.
  - START: tx_start=1, grant=onehot(sel), clear pending[sel], go to BUSY.
  - BUSY: grant held. On tx_done=1, set ptr <= (sel+1) mod N and go to IDLE. If TIMEOUT!=0 and the watchdog counter reaches TIMEOUT-1 without tx_done, pulse timeout for one cycle, set ptr <= (sel+1) mod N and go to IDLE.
- Winner selection: the first set pending bit scanning ptr, ptr+1, …, wrapping modulo N. ptr resets to 0.
- tx_done outside BUSY is ignored. tx_ready is ignored outside IDLE.
- Watchdog counter: cleared on entry to BUSY, increments each BUSY cycle. Width is ceil(log2(TIMEOUT+1)).
- Index widths are ceil(log2(N)). Wrap at N-1 -> 0 must hold for non-power-of-2 N.

## Timing
- Reset values:
  - tx_start, timeout: 0.
  - grant, pending, overrun: all 0.
  - tx_data: 0.
  - state: IDLE; ptr: 0.
- Reset asserted mid-transfer: the next cycle is IDLE with all slots empty, and no tx_start is issued. The transmitter is not notified.
- Pulse-to-start latency, with the scheduler idle and tx_ready=1:
  - req_pulse in cycle 0.
  - pending high in cycle 1; IDLE decides in cycle 1.
  - tx_start and grant high in cycle 2, with tx_data valid.
  - pending[i] low from cycle 3.
- tx_done sampled in cycle k moves the FSM to IDLE in cycle k+1. The next tx_start is earliest in cycle k+2.
- Minimum spacing between tx_start pulses is 3 cycles, assuming tx_done arrives on the first BUSY cycle.
- Timeout: the timeout pulse occurs in the TIMEOUT-th BUSY cycle, and the FSM is in IDLE on the following cycle.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Test plan
- Reset check: rst high for 2 cycles, then low. All outputs must be 0 and the FSM in IDLE.
- Single request: N=4, req_pulse=4'b0100, data 8'hA5, tx_ready=1. Expect tx_start in cycle 2, tx_data=8'hA5, grant=4'b0100. Pulse tx_done 10 cycles later; grant must be 0 on the next cycle.
- Round-robin fairness: all four requesters pulse together with data 8'h10..8'h13, and tx_done is answered after 5 BUSY cycles. Expect start order 0,1,2,3 with matching bytes. Re-fire 0 and 3 after ptr=0; expect order 0 then 3.
- Overrun: pulse requester 1 (8'h55) while it is pending but not yet started, then pulse it again with 8'hAA. Expect overrun=4'b0010 and a transmitted byte of 8'h55. Pulse ovr_clr; overrun must return to 0.
- Same-cycle refill: pulse requester 2 exactly in its START cycle with new data 8'h3C. Expect pending[2] to remain 1, no overrun, and 8'h3C sent on the next grant.
- Watchdog: TIMEOUT=16, never pulse tx_done. Expect a one-cycle timeout in BUSY cycle 16 and IDLE on the next cycle. Also assert rst during BUSY; expect IDLE with pending=0 and no further tx_start.
